trace_lockstep_checker: RTL and testbench
=========================================

// Module: trace_lockstep_checker
// PURPOSE
// - Synthesizable lockstep checker for two retire-trace streams, channel A and channel B (e.g. an optimised core and a golden core).
// - Buffers each stream in its own FIFO and compares the streams entry by entry.
// - Runs a cycle watchdog and reports a single pass/fail verdict with sticky error causes.
// - Successor to the plain-testbench trace dump and TIMEOUT: same checks, now in RTL, usable on FPGA or in Verilator.
// PARAMETERS
// - TRACE_W  36       width of one trace word
// - DEPTH    16       entries per channel FIFO; power of two, >=2
// - TIMEOUT  1000000  cycles after reset release before err_timeout fires; >=1
// - CNT_W    32       width of match_count; saturates at all-ones
// PORTS
// - clk           in   1        single clock, rising edge
// - resetn        in   1        synchronous, active-low reset
// - a_valid       in   1        channel A trace word valid this cycle
// - a_data        in   TRACE_W  channel A trace word
// - a_trap        in   1        channel A core trapped/finished (level or pulse)
// - b_valid       in   1        channel B trace word valid
// - b_data        in   TRACE_W  channel B trace word
// - b_trap        in   1        channel B trapped/finished
// - done          out  1        verdict reached (PASS or FAIL)
// - pass          out  1        streams matched completely
// - err_mismatch  out  1        compared words differed
// - err_overflow  out  2        bit0 = A FIFO overflow, bit1 = B FIFO overflow
// - err_length    out  1        streams ended with unequal counts
// - err_timeout   out  1        watchdog expired
// - match_count   out  CNT_W    number of equal word pairs compared
// BEHAVIOUR
// - Reset: resetn=0 sampled on a rising clk edge. All outputs go to 0. FIFOs empty, trap latches clear, watchdog = 0, state = RUN.
// - FSM states: RUN, DRAIN, PASS, FAIL. PASS and FAIL are terminal until reset.
// - Trap capture: a_trap/b_trap latch sticky trap_a/trap_b.
//   - *_valid is accepted while its trap latch is clear, including the cycle trap rises.
//   - *_valid is ignored once its latch is set.
// - Push: an accepted valid writes its FIFO at that edge. The word is compare-eligible from the next cycle.
// - Compare (RUN or DRAIN): when both FIFOs are non-empty, both heads pop in the same cycle.
//   - Equal heads: match_count increments at that edge.
//   - Unequal heads: err_mismatch=1 and FAIL on the next cycle.
// - Overflow: push into a full FIFO with no pop that cycle. The word is dropped, err_overflow[ch]=1, FAIL.
//   - Full FIFO + push + pop in the same cycle is legal: no overflow.
// - RUN -> DRAIN when trap_a && trap_b.
// - DRAIN exits:
//   - Both FIFOs empty -> PASS: done=1, pass=1.
//   - Exactly one FIFO empty -> err_length=1, FAIL.
// - Watchdog: counts each cycle in RUN/DRAIN. Reaching TIMEOUT -> err_timeout=1, FAIL.
// - Priority when errors coincide: every cause raised in that cycle is set. PASS is not taken if any error is raised in the same cycle.
// - FAIL: done=1, pass=0. Compares and pushes stop. All flags and match_count hold.
// - Outputs are registered; verdict and flags change only on clk edges.
// - Reset mid-run clears everything at that edge; any in-flight words are discarded.
// CONFIGURATION
// - MISMATCH_CAPTURE_EN defined adds three outputs:
//   - mm_data_a [TRACE_W], mm_data_b [TRACE_W]: the first unequal pair.
//   - mm_index [CNT_W]: match_count at that moment, i.e. the zero-based index of the pair.
//   - Loaded once, on the first mismatch; 0 after reset.
// - MISMATCH_CAPTURE_EN undefined: these ports and registers do not exist; all other behaviour is identical.
// TESTING
// - Both channels send identical 10 words (A and B skewed by 3 cycles), then both trap -> done=1, pass=1, match_count=10, all err*=0.
// - Word 5 of B is the A word with bit0 inverted -> err_mismatch=1, done=1, pass=0, match_count=4; with MISMATCH_CAPTURE_EN, mm_index=4 and mm_data_a/b differ in bit0.
// - DEPTH=16: A sends 17 back-to-back words, B silent -> err_overflow=2'b01 on the 17th word's edge, FAIL.
// - A sends 8 words, B sends 7, both trap -> match_count=7, err_length=1, pass=0.
// - TIMEOUT=100, no traps -> err_timeout=1 exactly 100 cycles after reset release, done=1.
// - Reset asserted mid-stream with 5 words buffered, then identical 3-word streams + traps -> pass=1, match_count=3.

Source files
------------

// File: rtl/trace_lockstep_checker.sv
// rtl/trace_lockstep_checker.sv - lockstep compare of two retire-trace streams with watchdog and verdict
// Optional feature: MISMATCH_CAPTURE_EN adds mm_data_a/mm_data_b/mm_index capture of the first unequal pair.
module trace_lockstep_checker #(
  parameter int TRACE_W = 36,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1000000,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               a_valid,
  input  logic [TRACE_W-1:0] a_data,
  input  logic               a_trap,
  input  logic               b_valid,
  input  logic [TRACE_W-1:0] b_data,
  input  logic               b_trap,
  output logic               done,
  output logic               pass,
  output logic               err_mismatch,
  output logic [1:0]         err_overflow,
  output logic               err_length,
  output logic               err_timeout,
`ifdef MISMATCH_CAPTURE_EN
  output logic [TRACE_W-1:0] mm_data_a,
  output logic [TRACE_W-1:0] mm_data_b,
  output logic [CNT_W-1:0]   mm_index,
`endif
  output logic [CNT_W-1:0]   match_count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_PASS, S_FAIL} state_t;
  state_t state, state_nx;

  logic [TRACE_W-1:0] fifo_a [DEPTH];
  logic [TRACE_W-1:0] fifo_b [DEPTH];
  logic [PW:0]        wr_a, rd_a, wr_b, rd_b;
  logic               trap_a, trap_b;
  logic [WD_W-1:0]    wdog;

  logic active, empty_a, empty_b, full_a, full_b;
  logic req_a, req_b, push_a, push_b, pop;
  logic ovf_a, ovf_b, mism, len_err, to_err, any_err;
  logic [TRACE_W-1:0] head_a, head_b;

  assign active  = (state == S_RUN) || (state == S_DRAIN);
  assign empty_a = (wr_a == rd_a);
  assign empty_b = (wr_b == rd_b);
  // Full when the pointers address the same slot but differ in the wrap bit.
  assign full_a  = (wr_a[PW-1:0] == rd_a[PW-1:0]) && (wr_a[PW] != rd_a[PW]);
  assign full_b  = (wr_b[PW-1:0] == rd_b[PW-1:0]) && (wr_b[PW] != rd_b[PW]);
  assign head_a  = fifo_a[rd_a[PW-1:0]];
  assign head_b  = fifo_b[rd_b[PW-1:0]];

  assign pop     = active && !empty_a && !empty_b;
  assign req_a   = active && a_valid && !trap_a;
  assign req_b   = active && b_valid && !trap_b;
  assign ovf_a   = req_a && full_a && !pop;
  assign ovf_b   = req_b && full_b && !pop;
  assign push_a  = req_a && !ovf_a;
  assign push_b  = req_b && !ovf_b;
  assign mism    = pop && (head_a != head_b);
  assign len_err = (state == S_DRAIN) && (empty_a != empty_b);
  assign to_err  = active && (wdog == WD_W'(TIMEOUT - 1));
  assign any_err = mism || ovf_a || ovf_b || len_err || to_err;

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_RUN;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RUN:   if (any_err) state_nx = S_FAIL;
               else if (trap_a && trap_b) state_nx = S_DRAIN;
      S_DRAIN: if (any_err) state_nx = S_FAIL;
               else if (empty_a && empty_b) state_nx = S_PASS;
      default: state_nx = state;
    endcase
  end

  always_comb begin
    done = (state == S_PASS) || (state == S_FAIL);
    pass = (state == S_PASS);
  end

  always_ff @(posedge clk) begin
    if (push_a) fifo_a[wr_a[PW-1:0]] <= a_data;
    if (push_b) fifo_b[wr_b[PW-1:0]] <= b_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_a <= '0; rd_a <= '0; wr_b <= '0; rd_b <= '0;
      trap_a <= 1'b0; trap_b <= 1'b0;
      wdog <= '0;
      err_mismatch <= 1'b0; err_overflow <= 2'b00;
      err_length <= 1'b0; err_timeout <= 1'b0;
      match_count <= '0;
    end else begin
      trap_a <= trap_a | a_trap;
      trap_b <= trap_b | b_trap;
      if (push_a) wr_a <= wr_a + 1'b1;
      if (push_b) wr_b <= wr_b + 1'b1;
      if (pop) begin
        rd_a <= rd_a + 1'b1;
        rd_b <= rd_b + 1'b1;
      end
      if (active) wdog <= wdog + 1'b1;
      if (pop && !mism && (match_count != '1)) match_count <= match_count + 1'b1;
      if (mism)    err_mismatch    <= 1'b1;
      if (ovf_a)   err_overflow[0] <= 1'b1;
      if (ovf_b)   err_overflow[1] <= 1'b1;
      if (len_err) err_length      <= 1'b1;
      if (to_err)  err_timeout     <= 1'b1;
    end
  end

`ifdef MISMATCH_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mm_data_a <= '0;
      mm_data_b <= '0;
      mm_index  <= '0;
    end else if (mism && !err_mismatch) begin
      mm_data_a <= head_a;
      mm_data_b <= head_b;
      mm_index  <= match_count;
    end
  end
`endif

endmodule

// File: tb/tb_trace_lockstep_checker.sv
// tb/tb_trace_lockstep_checker.sv - directed self-checking bench for trace_lockstep_checker
module tb_trace_lockstep_checker;

  localparam int TRACE_W = 36;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 100;
  localparam int CNT_W   = 32;

  logic               clk = 1'b0;
  logic               resetn;
  logic               a_valid, b_valid, a_trap, b_trap;
  logic [TRACE_W-1:0] a_data, b_data;
  logic               done, pass, err_mismatch, err_length, err_timeout;
  logic [1:0]         err_overflow;
  logic [CNT_W-1:0]   match_count;
`ifdef MISMATCH_CAPTURE_EN
  logic [TRACE_W-1:0] mm_data_a, mm_data_b;
  logic [CNT_W-1:0]   mm_index;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  trace_lockstep_checker #(
    .TRACE_W(TRACE_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn),
    .a_valid(a_valid), .a_data(a_data), .a_trap(a_trap),
    .b_valid(b_valid), .b_data(b_data), .b_trap(b_trap),
    .done(done), .pass(pass), .err_mismatch(err_mismatch),
    .err_overflow(err_overflow), .err_length(err_length),
    .err_timeout(err_timeout),
`ifdef MISMATCH_CAPTURE_EN
    .mm_data_a(mm_data_a), .mm_data_b(mm_data_b), .mm_index(mm_index),
`endif
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  function automatic logic [TRACE_W-1:0] w(input int i);
    return {4'h9, 32'(i) * 32'h0101_0103 + 32'h0000_1357};
  endfunction

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0; a_trap = 1'b0; b_trap = 1'b0;
    a_data = '0; b_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass got=%b exp=0", pass); end
    n_cmp++; if ({err_mismatch, err_overflow, err_length, err_timeout} !== 5'b0) begin
      n_bad++; $display("FAIL reset_errs got=%b exp=00000", {err_mismatch, err_overflow, err_length, err_timeout}); end
    n_cmp++; if (match_count !== '0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", match_count); end
`ifdef MISMATCH_CAPTURE_EN
    n_cmp++; if (mm_index !== '0 || mm_data_a !== '0 || mm_data_b !== '0) begin
      n_bad++; $display("FAIL reset_capture got=%0d/%h/%h exp=0", mm_index, mm_data_a, mm_data_b); end
`endif
    resetn = 1'b1;
  endtask

  task automatic test_match_skewed();
    bit ok;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      a_valid = (c < 10);            a_data = w(c);
      b_valid = (c >= 3 && c < 13);  b_data = w(c - 3);
      a_trap  = (c == 13);           b_trap = (c == 13);
      @(negedge clk);
    end
    idle_inputs();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL match_done_wait got=timeout exp=done"); end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL match_pass got=%b exp=1", pass); end
    n_cmp++; if (match_count !== 32'd10) begin n_bad++; $display("FAIL match_count got=%0d exp=10", match_count); end
    n_cmp++; if ({err_mismatch, err_overflow, err_length, err_timeout} !== 5'b0) begin
      n_bad++; $display("FAIL match_errs got=%b exp=00000", {err_mismatch, err_overflow, err_length, err_timeout}); end
  endtask

  task automatic test_mismatch();
    bit ok;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      a_valid = (c < 10); a_data = w(c);
      b_valid = (c < 10); b_data = (c == 4) ? (w(c) ^ 36'h1) : w(c);
      a_trap  = (c == 10); b_trap = (c == 10);
      @(negedge clk);
    end
    idle_inputs();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mism_done_wait got=timeout exp=done"); end
    n_cmp++; if (err_mismatch !== 1'b1) begin n_bad++; $display("FAIL mism_flag got=%b exp=1", err_mismatch); end
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL mism_pass got=%b exp=0", pass); end
    n_cmp++; if (match_count !== 32'd4) begin n_bad++; $display("FAIL mism_count got=%0d exp=4", match_count); end
    n_cmp++; if (err_length !== 1'b0 || err_overflow !== 2'b00) begin
      n_bad++; $display("FAIL mism_other_errs got=%b%b exp=000", err_length, err_overflow); end
`ifdef MISMATCH_CAPTURE_EN
    n_cmp++; if (mm_index !== 32'd4) begin n_bad++; $display("FAIL mism_index got=%0d exp=4", mm_index); end
    n_cmp++; if (mm_data_a !== w(4) || mm_data_b !== (w(4) ^ 36'h1)) begin
      n_bad++; $display("FAIL mism_capture got=%h/%h exp=%h/%h", mm_data_a, mm_data_b, w(4), w(4) ^ 36'h1); end
`endif
  endtask

  task automatic test_overflow();
    do_reset();
    for (int c = 0; c < 17; c++) begin
      a_valid = 1'b1; a_data = w(c);
      @(negedge clk);
      if (c == 15) begin
        n_cmp++; if (err_overflow !== 2'b00 || done !== 1'b0) begin
          n_bad++; $display("FAIL ovf_before got=%b/%b exp=00/0", err_overflow, done); end
      end
      if (c == 16) begin
        n_cmp++; if (err_overflow !== 2'b01) begin n_bad++; $display("FAIL ovf_flag got=%b exp=01", err_overflow); end
        n_cmp++; if (done !== 1'b1 || pass !== 1'b0) begin
          n_bad++; $display("FAIL ovf_verdict got=%b%b exp=10", done, pass); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_full_push_pop();
    bit ok;
    do_reset();
    for (int c = 0; c < 34; c++) begin
      a_valid = (c < 16) || (c == 17); a_data = (c == 17) ? w(16) : w(c);
      b_valid = (c >= 16 && c < 33);   b_data = w(c - 16);
      a_trap  = (c == 33);             b_trap = (c == 33);
      @(negedge clk);
    end
    idle_inputs();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fullpp_done_wait got=timeout exp=done"); end
    n_cmp++; if (err_overflow !== 2'b00) begin n_bad++; $display("FAIL fullpp_ovf got=%b exp=00", err_overflow); end
    n_cmp++; if (pass !== 1'b1 || match_count !== 32'd17) begin
      n_bad++; $display("FAIL fullpp_result got=pass%b/%0d exp=pass1/17", pass, match_count); end
  endtask

  task automatic test_length();
    bit ok;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      a_valid = (c < 8); a_data = w(c);
      b_valid = (c < 7); b_data = w(c);
      a_trap  = (c == 8); b_trap = (c == 8);
      @(negedge clk);
    end
    idle_inputs();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL len_done_wait got=timeout exp=done"); end
    n_cmp++; if (err_length !== 1'b1) begin n_bad++; $display("FAIL len_flag got=%b exp=1", err_length); end
    n_cmp++; if (match_count !== 32'd7) begin n_bad++; $display("FAIL len_count got=%0d exp=7", match_count); end
    n_cmp++; if (pass !== 1'b0 || err_mismatch !== 1'b0) begin
      n_bad++; $display("FAIL len_pass_mism got=%b%b exp=00", pass, err_mismatch); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (TIMEOUT - 1) @(negedge clk);
    n_cmp++; if (err_timeout !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL tmo_early got=%b/%b exp=0/0", err_timeout, done); end
    @(negedge clk);
    n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_flag got=%b exp=1", err_timeout); end
    n_cmp++; if (done !== 1'b1 || pass !== 1'b0) begin
      n_bad++; $display("FAIL tmo_verdict got=%b%b exp=10", done, pass); end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      a_valid = 1'b1; a_data = w(100 + c);
      @(negedge clk);
    end
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || match_count !== '0) begin
      n_bad++; $display("FAIL midrst_clear got=%b/%0d exp=0/0", done, match_count); end
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      a_valid = (c < 3); a_data = w(c);
      b_valid = (c < 3); b_data = w(c);
      a_trap  = (c == 3); b_trap = (c == 3);
      @(negedge clk);
    end
    idle_inputs();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL midrst_done_wait got=timeout exp=done"); end
    n_cmp++; if (pass !== 1'b1 || match_count !== 32'd3) begin
      n_bad++; $display("FAIL midrst_result got=pass%b/%0d exp=pass1/3", pass, match_count); end
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    test_reset();
    test_match_skewed();
    test_mismatch();
    test_overflow();
    test_full_push_pop();
    test_length();
    test_timeout();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
